elevator_car_sequencer: RTL



---
 rtl/elevator_pkg.sv | 23 ++
 rtl/elevator_phase_timer.sv | 27 ++
 rtl/elevator_car_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car sequencing block.
package elevator_pkg;

  typedef enum logic [2:0] {
    ST_PARKED       = 3'd0,
    ST_TRAVEL_UP    = 3'd1,
    ST_TRAVEL_DOWN  = 3'd2,
    ST_DOOR_OPENING = 3'd3,
    ST_DWELL        = 3'd4,
    ST_DOOR_CLOSING = 3'd5,
    ST_HALT         = 3'd6
  } state_e;

  localparam logic FLOOR_1 = 1'b0;
  localparam logic FLOOR_2 = 1'b1;

  // Car is standing at a landing (not travelling, not halted).
  function automatic logic is_stationary(state_e s);
    return (s == ST_PARKED) || (s == ST_DOOR_OPENING) ||
           (s == ST_DWELL)  || (s == ST_DOOR_CLOSING);
  endfunction

endpackage

// File: rtl/elevator_phase_timer.sv
// Down-counter timing each sequencer phase; done when the count reaches zero.
module elevator_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load on strobe, otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/elevator_car_sequencer.sv
// Sequences car travel and door motion for a two-floor elevator.
//
// state           | meaning
// PARKED          | door closed, waiting for a request to the other floor
// TRAVEL_UP       | motor driving car from floor 1 to floor 2
// TRAVEL_DOWN     | motor driving car from floor 2 to floor 1
// DOOR_OPENING    | door opening motion
// DWELL           | door fully open, held while obstructed
// DOOR_CLOSING    | door closing motion, obstruction reopens fully
// HALT            | emergency stop latched until reset
module elevator_car_sequencer
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 4,
  parameter int DWELL_CYCLES  = 8,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic target_1_i,
  input  logic target_2_i,
  input  logic door_obstruct_i,
  input  logic estop_i,
  output logic motor_up_o,
  output logic motor_down_o,
  output logic door_open_cmd_o,
  output logic door_close_cmd_o,
  output logic door_is_open_o,
  output logic at_floor_1_o,
  output logic at_floor_2_o,
  output logic busy_o,
  output logic fault_o
);

  localparam logic [CNT_W-1:0] LD_TRAVEL = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_DOOR   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_DWELL  = CNT_W'(DWELL_CYCLES - 1);

  state_e           state_q, state_d;
  logic             pos_q, pos_d;
  logic             timer_load;
  logic [CNT_W-1:0] timer_load_val;
  logic             timer_done;

  logic motor_up_q, motor_down_q, door_open_q, door_close_q, door_is_open_q;
  logic at_floor_1_q, at_floor_2_q, busy_q, fault_q;

  elevator_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (timer_load_val),
    .done_o     (timer_done)
  );

  // Next state, car position and timer reload; estop outranks everything.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    timer_load = 1'b0;
    if (estop_i) begin
      state_d = ST_HALT;
    end else begin
      case (state_q)
        ST_PARKED: begin
          if (target_2_i && !target_1_i && pos_q == FLOOR_1)      state_d = ST_TRAVEL_UP;
          else if (target_1_i && !target_2_i && pos_q == FLOOR_2) state_d = ST_TRAVEL_DOWN;
        end
        ST_TRAVEL_UP, ST_TRAVEL_DOWN: begin
          if (timer_done) begin
            state_d = ST_DOOR_OPENING;
            pos_d   = ~pos_q;
          end
        end
        ST_DOOR_OPENING: if (timer_done) state_d = ST_DWELL;
        ST_DWELL: begin
          if (door_obstruct_i) timer_load = 1'b1;
          else if (timer_done) state_d = ST_DOOR_CLOSING;
        end
        ST_DOOR_CLOSING: begin
          if (door_obstruct_i) state_d = ST_DOOR_OPENING;
          else if (timer_done) state_d = ST_PARKED;
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_HALT;
      endcase
    end
    if (state_d != state_q) timer_load = 1'b1;
  end

  // Phase length loaded for whichever state is being entered.
  always_comb begin
    case (state_d)
      ST_TRAVEL_UP, ST_TRAVEL_DOWN:     timer_load_val = LD_TRAVEL;
      ST_DOOR_OPENING, ST_DOOR_CLOSING: timer_load_val = LD_DOOR;
      ST_DWELL:                         timer_load_val = LD_DWELL;
      default:                          timer_load_val = '0;
    endcase
  end

  // State, position and registered Moore outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_PARKED;
      pos_q          <= FLOOR_1;
      motor_up_q     <= 1'b0;
      motor_down_q   <= 1'b0;
      door_open_q    <= 1'b0;
      door_close_q   <= 1'b0;
      door_is_open_q <= 1'b0;
      at_floor_1_q   <= 1'b1;
      at_floor_2_q   <= 1'b0;
      busy_q         <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      motor_up_q     <= (state_d == ST_TRAVEL_UP);
      motor_down_q   <= (state_d == ST_TRAVEL_DOWN);
      door_open_q    <= (state_d == ST_DOOR_OPENING);
      door_close_q   <= (state_d == ST_DOOR_CLOSING);
      door_is_open_q <= (state_d == ST_DWELL);
      at_floor_1_q   <= is_stationary(state_d) && (pos_d == FLOOR_1);
      at_floor_2_q   <= is_stationary(state_d) && (pos_d == FLOOR_2);
      busy_q         <= (state_d != ST_PARKED);
      fault_q        <= (state_d == ST_HALT);
    end
  end

  assign motor_up_o       = motor_up_q;
  assign motor_down_o     = motor_down_q;
  assign door_open_cmd_o  = door_open_q;
  assign door_close_cmd_o = door_close_q;
  assign door_is_open_o   = door_is_open_q;
  assign at_floor_1_o     = at_floor_1_q;
  assign at_floor_2_o     = at_floor_2_q;
  assign busy_o           = busy_q;
  assign fault_o          = fault_q;

endmodule
